// File: rtl/clk_gen_param.sv
// Parametrised CPU / memory clock generator with reset hold and
// halt / single-step control, all running from one fast source clock.
module clk_gen_param #(
  parameter int HALF_PERIOD  = 2,
  parameter int MEM_PHASE    = 1,
  parameter int RESET_CYCLES = 3
) (
  input  logic clk_in,
  input  logic n_reset_in,
  input  logic halt,
  input  logic step,
  output logic clk,
  output logic mem_clk,
  output logic n_reset_out,
  output logic running,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int PERIOD = 2 * HALF_PERIOD;
  localparam int PW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(HALF_PERIOD);
  localparam logic [PW:0]   MEM_OFS = (PW + 1)'(PERIOD - MEM_PHASE);
  localparam logic [PW:0]   PER_W   = (PW + 1)'(PERIOD);
  localparam logic [7:0]    RC_LAST =
    8'((RESET_CYCLES == 0) ? 0 : RESET_CYCLES - 1);

  if (HALF_PERIOD < 1)
    $error("HALF_PERIOD must be >= 1");
  if (MEM_PHASE < 0 || MEM_PHASE >= HALF_PERIOD)
    $error("MEM_PHASE must be 0..HALF_PERIOD-1");
  if (RESET_CYCLES < 0 || RESET_CYCLES > 255)
    $error("RESET_CYCLES must be 0..255");

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] ph;
  logic [PW-1:0] ph_n;
  logic          step_q;
  logic [7:0]    rst_cnt;
  logic [7:0]    rst_cnt_n;

  logic          adv;
  logic          at_last;
  logic          wrap;
  logic          step_edge;

  logic          clk_n;
  logic          mem_n;
  logic [PW:0]   mem_ph;
  logic          rise_n;
  logic          fall_n;
  logic          run_n;
  logic          nro_n;

  assign at_last   = (ph == PH_LAST);
  assign step_edge = step & ~step_q;

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state       <= RUN;
      ph          <= '0;
      step_q      <= 1'b0;
      rst_cnt     <= '0;
      clk         <= 1'b0;
      mem_clk     <= 1'b0;
      n_reset_out <= 1'b0;
      running     <= 1'b0;
      rise_tick   <= 1'b0;
      fall_tick   <= 1'b0;
    end else begin
      state       <= state_n;
      ph          <= ph_n;
      step_q      <= step;
      rst_cnt     <= rst_cnt_n;
      clk         <= clk_n;
      mem_clk     <= mem_n;
      n_reset_out <= nro_n;
      running     <= run_n;
      rise_tick   <= rise_n;
      fall_tick   <= fall_n;
    end
  end

  // HALTED parks ph at 0, so leaving it always advances to 1.
  always_comb begin
    state_n = state;
    adv     = 1'b0;
    unique case (state)
      RUN: begin
        adv = 1'b1;
        if (at_last && halt)
          state_n = HALTED;
      end
      HALTED: begin
        if (!halt) begin
          adv     = 1'b1;
          state_n = RUN;
        end else if (step_edge) begin
          adv     = 1'b1;
          state_n = STEP;
        end
      end
      STEP: begin
        adv = 1'b1;
        if (at_last)
          state_n = halt ? HALTED : RUN;
      end
      default: state_n = RUN;
    endcase
    wrap = adv & at_last;
    ph_n = ph;
    if (adv)
      ph_n = at_last ? '0 : ph + PW'(1);
  end

  always_comb begin
    clk_n  = (ph_n >= PH_HALF);
    mem_ph = {1'b0, ph_n} + MEM_OFS;
    if (mem_ph >= PER_W)
      mem_ph = mem_ph - PER_W;
    mem_n  = (mem_ph >= {1'b0, PH_HALF});
    rise_n = clk_n & ~clk;
    fall_n = ~clk_n & clk;
    run_n  = (state_n != HALTED);

    rst_cnt_n = rst_cnt;
    nro_n     = n_reset_out;
    if (!n_reset_out) begin
      if (RESET_CYCLES == 0) begin
        nro_n = 1'b1;
      end else if (wrap) begin
        rst_cnt_n = rst_cnt + 8'd1;
        if (rst_cnt == RC_LAST)
          nro_n = 1'b1;
      end
    end
  end

endmodule
